// File: rtl/bcd_stopwatch_ctrl.sv
// BCD stopwatch controller: prescaled tick, rippled digit chain, run/pause/done
// FSM driven by button edges, and a lap snapshot that can freeze the display.
module bcd_stopwatch_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 10,
    parameter int WRAP       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_stop,
    input  logic                    clear,
    input  logic                    lap,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    running,
    output logic                    lap_hold,
    output logic                    overflow
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [PW-1:0]           presc;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [4*NUM_DIGITS-1:0] digits_next;
    logic [4*NUM_DIGITS-1:0] lap_reg;
    logic [NUM_DIGITS-1:0]   inc;
    logic                    tick;
    logic                    terminal;

    logic start_stop_d;
    logic clear_d;
    logic lap_d;
    logic start_stop_ev;
    logic clear_ev;
    logic lap_ev;
    logic lap_allowed;

    // NOTE: sequential state always uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_stop_d <= 1'b0;
            clear_d      <= 1'b0;
            lap_d        <= 1'b0;
        end else begin
            start_stop_d <= start_stop;
            clear_d      <= clear;
            lap_d        <= lap;
        end
    end

    assign start_stop_ev = start_stop & ~start_stop_d;
    assign clear_ev      = clear & ~clear_d;
    assign lap_ev        = lap & ~lap_d;
    assign lap_allowed   = (state == ST_RUN) || (state == ST_PAUSE);

    assign tick = (state == ST_RUN) && (presc == PRESC_LAST);

    // Digit i advances when the tick ripples through all lower digits at 9;
    // a carry out of the top digit is the terminal count.
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        logic low_nines;
        inc       = '0;
        low_nines = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            inc[i]    = tick && low_nines;
            low_nines = low_nines && (digits[4*i +: 4] == 4'd9);
        end
        terminal = tick && low_nines;
    end

    always_comb begin
        digits_next = digits;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (inc[i]) begin
                digits_next[4*i +: 4] = (digits[4*i +: 4] == 4'd9) ? 4'd0
                                                                     : digits[4*i +: 4] + 4'd1;
            end
        end
        if (terminal && (WRAP == 0)) begin
            digits_next = digits;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_stop_ev) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (terminal && (WRAP == 0)) state_next = ST_DONE;
                else if (start_stop_ev)      state_next = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (start_stop_ev) state_next = ST_RUN;
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
        endcase
        if (clear_ev) begin
            state_next = ST_IDLE;
        end
    end

    // NOTE: lap_reg is an ordinary register reset with the rest, so the first
    // frozen display can never show power-up garbage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc    <= '0;
            digits   <= '0;
            lap_reg  <= '0;
            lap_hold <= 1'b0;
            overflow <= 1'b0;
        end else if (clear_ev) begin
            presc    <= '0;
            digits   <= '0;
            lap_hold <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (state == ST_RUN) begin
                presc <= tick ? '0 : presc + PW'(1);
            end
            digits <= digits_next;

            // Snapshot uses the pre-increment digits even when a tick lands here.
            if (lap_ev && lap_allowed) begin
                if (!lap_hold) begin
                    lap_reg  <= digits;
                    lap_hold <= 1'b1;
                end else begin
                    lap_hold <= 1'b0;
                end
            end

            if (WRAP != 0) begin
                overflow <= terminal;
            end else if (terminal) begin
                overflow <= 1'b1;
            end
        end
    end

    assign bcd_out = lap_hold ? lap_reg : digits;
    assign running = (state == ST_RUN);

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: a saturating and a wrapping instance share stimulus
// and are compared every cycle against an integer-count reference model.
module tb_bcd_stopwatch_ctrl;

    localparam int ND     = 2;
    localparam int TD     = 4;
    localparam int MAXV   = 99;
    localparam int BUDGET = 3000;

    logic          clk;
    logic          rst;
    logic          start_stop;
    logic          clear;
    logic          lap;
    logic [4*ND-1:0] bcd_s, bcd_w;
    logic          run_s, run_w;
    logic          hold_s, hold_w;
    logic          ovf_s, ovf_w;

    int total = 0;
    int bad   = 0;

    bcd_stopwatch_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD), .WRAP(0)) u_sat (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
        .bcd_out(bcd_s), .running(run_s), .lap_hold(hold_s), .overflow(ovf_s)
    );

    bcd_stopwatch_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
        .bcd_out(bcd_w), .running(run_w), .lap_hold(hold_w), .overflow(ovf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 saturates, index 1 wraps. Count is a plain integer.
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_e;
    mstate_e m_st[2];
    int      m_cnt[2];
    int      m_pre[2];
    int      m_lap[2];
    bit      m_hold[2];
    bit      m_ovf[2];
    bit      p_ss, p_clr, p_lap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [7:0] exp_bcd(input int k);
        return m_hold[k] ? to_bcd(m_lap[k]) : to_bcd(m_cnt[k]);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k]   = M_IDLE;
            m_cnt[k]  = 0;
            m_pre[k]  = 0;
            m_lap[k]  = 0;
            m_hold[k] = 1'b0;
            m_ovf[k]  = 1'b0;
        end
        p_ss  = 1'b0;
        p_clr = 1'b0;
        p_lap = 1'b0;
    endfunction

    function automatic void model_step();
        bit      e_ss, e_clr, e_lap, tk, term;
        mstate_e st0;
        e_ss  = start_stop && !p_ss;
        e_clr = clear && !p_clr;
        e_lap = lap && !p_lap;
        for (int k = 0; k < 2; k++) begin
            st0 = m_st[k];
            if (e_clr) begin
                m_st[k]   = M_IDLE;
                m_cnt[k]  = 0;
                m_pre[k]  = 0;
                m_hold[k] = 1'b0;
                m_ovf[k]  = 1'b0;
            end else begin
                tk   = (st0 == M_RUN) && (m_pre[k] == TD - 1);
                term = tk && (m_cnt[k] == MAXV);
                if (k == 1) m_ovf[k] = 1'b0;
                if (st0 == M_RUN) m_pre[k] = tk ? 0 : m_pre[k] + 1;
                if (e_lap && (st0 == M_RUN || st0 == M_PAUSE)) begin
                    if (!m_hold[k]) begin
                        m_lap[k]  = m_cnt[k];
                        m_hold[k] = 1'b1;
                    end else begin
                        m_hold[k] = 1'b0;
                    end
                end
                if (term) begin
                    m_ovf[k] = 1'b1;
                    if (k == 0) m_st[k] = M_DONE;
                    else        m_cnt[k] = 0;
                end else if (tk) begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
                if (e_ss && !(term && k == 0)) begin
                    case (st0)
                        M_IDLE:  m_st[k] = M_RUN;
                        M_RUN:   m_st[k] = M_PAUSE;
                        M_PAUSE: m_st[k] = M_RUN;
                        default: ;
                    endcase
                end
            end
        end
        p_ss  = start_stop;
        p_clr = clear;
        p_lap = lap;
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (rst) model_step();
        else     model_reset();
        @(negedge clk);
        check("bcd_sat",  32'(bcd_s),  32'(exp_bcd(0)));
        check("run_sat",  32'(run_s),  32'(m_st[0] == M_RUN));
        check("hold_sat", 32'(hold_s), 32'(m_hold[0]));
        check("ovf_sat",  32'(ovf_s),  32'(m_ovf[0]));
        check("bcd_wrap", 32'(bcd_w),  32'(exp_bcd(1)));
        check("run_wrap", 32'(run_w),  32'(m_st[1] == M_RUN));
        check("hold_wrap",32'(hold_w), 32'(m_hold[1]));
        check("ovf_wrap", 32'(ovf_w),  32'(m_ovf[1]));
    endtask

    task automatic drive(input bit ss, input bit cl, input bit lp, input int n);
        start_stop = ss;
        clear      = cl;
        lap        = lp;
        repeat (n) cycle();
    endtask

    task automatic run_until(input int target, input bit at_tick);
        int n = 0;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        while (!(m_cnt[0] == target && (!at_tick || m_pre[0] == TD - 1)) && n < BUDGET) begin
            cycle();
            n++;
        end
        check("wait_reached", 32'(n < BUDGET), 32'd1);
    endtask

    initial begin
        rst        = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_bcd",  32'(bcd_s),  32'h0);
        check("reset_run",  32'(run_s),  32'h0);
        check("reset_hold", 32'(hold_s), 32'h0);
        check("reset_ovf",  32'(ovf_s),  32'h0);
        rst = 1'b1;

        // One long press is one event; ten ticks later the count reads 10.
        drive(1, 0, 0, 20);
        drive(0, 0, 0, 21);
        check("count_10", 32'(bcd_s), 32'h10);
        check("count_run", 32'(run_s), 32'h1);

        // Pause at 05, hold, resume with the partial tick preserved.
        drive(0, 1, 0, 1);
        drive(0, 0, 0, 1);
        check("clear_zero", 32'(bcd_s), 32'h0);
        drive(1, 0, 0, 1);
        run_until(5, 0);
        drive(1, 0, 0, 1);
        drive(0, 0, 0, 50);
        check("pause_hold", 32'(bcd_s), 32'h05);
        check("pause_run", 32'(run_s), 32'h0);
        drive(1, 0, 0, 1);
        drive(0, 0, 0, 2);
        check("resume_early", 32'(bcd_s), 32'h05);
        drive(0, 0, 0, 1);
        check("resume_tick", 32'(bcd_s), 32'h06);

        // Lap freeze at 12 while counting on to 20, then release.
        run_until(12, 0);
        drive(0, 0, 1, 1);
        run_until(20, 0);
        check("lap_frozen", 32'(bcd_s), 32'h12);
        check("lap_hold_on", 32'(hold_s), 32'h1);
        drive(0, 0, 1, 1);
        check("lap_release", 32'(bcd_s), 32'h20);
        check("lap_hold_off", 32'(hold_s), 32'h0);

        // Lap on the same edge as the 19->20 tick keeps the pre-tick value.
        drive(0, 1, 0, 1);
        drive(1, 0, 0, 1);
        run_until(19, 1);
        drive(0, 0, 1, 1);
        check("lap_on_tick", 32'(bcd_s), 32'h19);
        drive(0, 0, 0, 4);
        drive(0, 0, 1, 1);

        // Terminal count: saturate vs wrap.
        run_until(MAXV, 1);
        drive(0, 0, 0, 1);
        check("sat_bcd", 32'(bcd_s), 32'h99);
        check("sat_ovf", 32'(ovf_s), 32'h1);
        check("sat_run", 32'(run_s), 32'h0);
        check("wrap_bcd", 32'(bcd_w), 32'h00);
        check("wrap_ovf", 32'(ovf_w), 32'h1);
        check("wrap_run", 32'(run_w), 32'h1);
        drive(0, 0, 0, 1);
        check("wrap_ovf_pulse", 32'(ovf_w), 32'h0);
        check("sat_ovf_sticky", 32'(ovf_s), 32'h1);
        drive(1, 0, 0, 1);
        drive(0, 0, 0, 5);
        check("done_ignore_ss", 32'(run_s), 32'h0);
        check("done_bcd", 32'(bcd_s), 32'h99);
        drive(0, 1, 0, 1);
        check("done_clear_bcd", 32'(bcd_s), 32'h0);
        check("done_clear_ovf", 32'(ovf_s), 32'h0);
        drive(0, 0, 0, 1);

        // Clear beats start_stop in the same cycle.
        drive(1, 0, 0, 1);
        drive(0, 0, 0, 10);
        drive(1, 1, 0, 1);
        check("clr_prio_run", 32'(run_s), 32'h0);
        check("clr_prio_bcd", 32'(bcd_s), 32'h0);
        drive(0, 0, 0, 1);

        // Asynchronous reset mid-run, then stay idle until a start edge.
        drive(1, 0, 0, 1);
        drive(0, 0, 0, 13);
        #2 rst = 1'b0;
        #1;
        check("async_bcd", 32'(bcd_s), 32'h0);
        check("async_run", 32'(run_s), 32'h0);
        check("async_wrap_bcd", 32'(bcd_w), 32'h0);
        model_reset();
        drive(0, 0, 0, 2);
        rst = 1'b1;
        drive(0, 0, 0, 10);
        check("post_rst_idle", 32'(run_s), 32'h0);
        check("post_rst_bcd", 32'(bcd_s), 32'h0);

        // Random button activity against the model.
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(39) == 0) start_stop = !start_stop;
            if ($urandom_range(49) == 0) lap = !lap;
            clear = ($urandom_range(699) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
